// File: rtl/mcp300x_scanner.sv
`default_nettype none
// ============================================================================
// mcp300x_scanner : round-robin channel scanner for an MCP300x converter core
// Revision        : 1.0
// ============================================================================
module mcp300x_scanner #(
    parameter int CLK_DIV = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic [7:0] ch_mask_i,
    input  logic       single_i,
    output logic       ena_o,
    output logic       start_o,
    output logic [2:0] chn_o,
    output logic       single_o,
    input  logic       busy_i,
    input  logic       eoc_i,
    input  logic [9:0] data_i,
    input  logic [2:0] rd_chn_i,
    output logic [9:0] rd_data_o,
    output logic [7:0] valid_o,
    output logic       scan_done_o,
    output logic       err_o
);
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_START    = 2'd1,
        S_WAIT_EOC = 2'd2,
        S_NEXT     = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  div_q;
    logic        ena_q;
    logic [15:0] tmo_q;
    logic [2:0]  ptr_q;
    logic [2:0]  chn_q;
    logic        single_q;
    logic        start_q;
    logic        scan_done_q;
    logic        err_q;
    logic [7:0]  valid_q;
    logic [9:0]  data_q [8];

    logic        sel_found_d;
    logic [2:0]  sel_chn_d;
    logic [7:0]  upper_mask_d;
    logic        wrap_d;

    // Lowest enabled channel at or after the pointer, wrapping past 7 to 0.
    always_comb begin
        sel_found_d = 1'b0;
        sel_chn_d   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!sel_found_d && ch_mask_i[3'(ptr_q + 3'(i))]) begin
                sel_found_d = 1'b1;
                sel_chn_d   = 3'(ptr_q + 3'(i));
            end
        end
    end

    // Channels strictly above chn_q; empty for channel 7 since 2<<7 wraps to 0.
    assign upper_mask_d = ~((8'd2 << chn_q) - 8'd1);
    assign wrap_d       = (ch_mask_i & upper_mask_d) == 8'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            div_q       <= 8'd0;
            ena_q       <= 1'b0;
            tmo_q       <= 16'd0;
            ptr_q       <= 3'd0;
            chn_q       <= 3'd0;
            single_q    <= 1'b0;
            start_q     <= 1'b0;
            scan_done_q <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 8'd0;
            for (int n = 0; n < 8; n++) begin
                data_q[n] <= 10'd0;
            end
        end else begin
            div_q       <= (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
            ena_q       <= (div_q == DIV_LAST);
            scan_done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (run_i && sel_found_d) begin
                        chn_q    <= sel_chn_d;
                        single_q <= single_i;
                        start_q  <= 1'b1;
                        tmo_q    <= 16'd0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    tmo_q <= tmo_q + 16'd1;
                    if (tmo_q >= TMO_LAST) begin
                        err_q   <= 1'b1;
                        start_q <= 1'b0;
                        ptr_q   <= chn_q + 3'd1;
                        state_q <= S_IDLE;
                    end else if (busy_i) begin
                        start_q <= 1'b0;
                        state_q <= S_WAIT_EOC;
                    end
                end
                S_WAIT_EOC: begin
                    tmo_q <= tmo_q + 16'd1;
                    if (eoc_i) begin
                        data_q[chn_q]  <= data_i;
                        valid_q[chn_q] <= 1'b1;
                        scan_done_q    <= wrap_d;
                        state_q        <= S_NEXT;
                    end else if (tmo_q >= TMO_LAST) begin
                        err_q   <= 1'b1;
                        start_q <= 1'b0;
                        ptr_q   <= chn_q + 3'd1;
                        state_q <= S_IDLE;
                    end
                end
                S_NEXT: begin
                    ptr_q   <= chn_q + 3'd1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ena_o       = ena_q;
    assign start_o     = start_q;
    assign chn_o       = chn_q;
    assign single_o    = single_q;
    assign scan_done_o = scan_done_q;
    assign err_o       = err_q;
    assign valid_o     = valid_q;
    assign rd_data_o   = data_q[rd_chn_i];

endmodule
`default_nettype wire

// File: tb/tb_mcp300x_scanner.sv
`default_nettype none
// ============================================================================
// tb_mcp300x_scanner : scenario tests for mcp300x_scanner with a converter model
// Revision           : 1.0
// ============================================================================
module tb_mcp300x_scanner;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       run_i = 1'b0;
    logic [7:0] ch_mask_i = 8'd0;
    logic       single_i = 1'b0;
    logic       busy_i = 1'b0;
    logic       eoc_i = 1'b0;
    logic [9:0] data_i = 10'd0;
    logic [2:0] rd_chn_i = 3'd0;
    logic       ena_o, start_o, single_o, scan_done_o, err_o;
    logic [2:0] chn_o;
    logic [9:0] rd_data_o;
    logic [7:0] valid_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] exp_chn_q  [$];
    logic [9:0] exp_data_q [$];

    always #5 clk_i = ~clk_i;

    mcp300x_scanner #(
        .CLK_DIV (4),
        .TIMEOUT (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .run_i       (run_i),
        .ch_mask_i   (ch_mask_i),
        .single_i    (single_i),
        .ena_o       (ena_o),
        .start_o     (start_o),
        .chn_o       (chn_o),
        .single_o    (single_o),
        .busy_i      (busy_i),
        .eoc_i       (eoc_i),
        .data_i      (data_i),
        .rd_chn_i    (rd_chn_i),
        .rd_data_o   (rd_data_o),
        .valid_o     (valid_o),
        .scan_done_o (scan_done_o),
        .err_o       (err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (start_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Converter model: acknowledge with busy, then deliver one eoc pulse.
    task automatic convert(input logic [9:0] data);
        busy_i = 1'b1;
        tick();
        tick();
        eoc_i  = 1'b1;
        data_i = data;
        exp_data_q.push_back(data);
        tick();
        eoc_i  = 1'b0;
        busy_i = 1'b0;
        data_i = 10'd0;
    endtask

    task automatic test_reset();
        bit bad;
        rst_i = 1'b1;
        tick();
        tick();
        n_checks++; if (start_o !== 1'b0) $display("FAIL rst_start: got %b want 0", start_o); else n_pass++;
        n_checks++; if (chn_o !== 3'd0) $display("FAIL rst_chn: got %0d want 0", chn_o); else n_pass++;
        n_checks++; if (single_o !== 1'b0) $display("FAIL rst_single: got %b want 0", single_o); else n_pass++;
        n_checks++; if (ena_o !== 1'b0) $display("FAIL rst_ena: got %b want 0", ena_o); else n_pass++;
        n_checks++; if (scan_done_o !== 1'b0) $display("FAIL rst_done: got %b want 0", scan_done_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o); else n_pass++;
        n_checks++; if (valid_o !== 8'h00) $display("FAIL rst_valid: got %h want 00", valid_o); else n_pass++;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            rd_chn_i = 3'(c);
            #1;
            if (rd_data_o !== 10'd0) bad = 1'b1;
        end
        n_checks++; if (bad) $display("FAIL rst_regs: got nonzero want all 0"); else n_pass++;
    endtask

    task automatic test_divider();
        logic exp;
        rst_i = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp = ((k % 4) == 0);
            n_checks++; if (ena_o !== exp) $display("FAIL div_ena clk %0d: got %b want %b", k, ena_o, exp); else n_pass++;
        end
    endtask

    task automatic test_scan_two_channels();
        bit ok, s1, s2, seen;
        logic [2:0] exp_c;
        logic [9:0] exp_d;
        logic [9:0] table_d [8];
        table_d[0] = 10'h155;
        table_d[2] = 10'h2AA;
        exp_chn_q.push_back(3'd0);
        exp_chn_q.push_back(3'd2);
        exp_chn_q.push_back(3'd0);
        single_i  = 1'b1;
        ch_mask_i = 8'h05;
        run_i     = 1'b1;
        for (int it = 0; it < 3; it++) begin
            wait_start(ok);
            n_checks++; if (!ok) begin $display("FAIL scan_start_timeout: got no start want start"); break; end else n_pass++;
            exp_c = exp_chn_q.pop_front();
            n_checks++; if (chn_o !== exp_c) $display("FAIL scan_chn: got %0d want %0d", chn_o, exp_c); else n_pass++;
            n_checks++; if (single_o !== 1'b1) $display("FAIL scan_single: got %b want 1", single_o); else n_pass++;
            rd_chn_i = exp_c;
            convert(table_d[exp_c]);
            if (it == 2) run_i = 1'b0;
            n_checks++; if (scan_done_o !== (exp_c == 3'd2)) $display("FAIL scan_done: got %b want %b", scan_done_o, exp_c == 3'd2); else n_pass++;
            exp_d = exp_data_q.pop_front();
            n_checks++; if (rd_data_o !== exp_d) $display("FAIL scan_store: got %h want %h", rd_data_o, exp_d); else n_pass++;
            if (it < 2) begin
                tick();
                s1 = start_o;
                tick();
                s2 = start_o;
                n_checks++; if ({s1, s2} !== 2'b01) $display("FAIL scan_latency: got %b%b want 01", s1, s2); else n_pass++;
            end
        end
        rd_chn_i = 3'd0;
        #1;
        n_checks++; if (rd_data_o !== 10'h155) $display("FAIL scan_rd0: got %h want 155", rd_data_o); else n_pass++;
        rd_chn_i = 3'd2;
        #1;
        n_checks++; if (rd_data_o !== 10'h2AA) $display("FAIL scan_rd2: got %h want 2aa", rd_data_o); else n_pass++;
        n_checks++; if (valid_o !== 8'h05) $display("FAIL scan_valid: got %h want 05", valid_o); else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (start_o) seen = 1'b1;
        end
        n_checks++; if (seen) $display("FAIL scan_stop: got start want none"); else n_pass++;
    endtask

    task automatic test_single_channel_diff();
        bit ok;
        logic [9:0] exp_d;
        logic [9:0] vals [3];
        vals[0] = 10'h0F0;
        vals[1] = 10'h30F;
        vals[2] = 10'h001;
        single_i  = 1'b0;
        ch_mask_i = 8'h80;
        run_i     = 1'b1;
        rd_chn_i  = 3'd7;
        for (int it = 0; it < 3; it++) begin
            wait_start(ok);
            n_checks++; if (!ok) begin $display("FAIL ch7_start_timeout: got no start want start"); break; end else n_pass++;
            n_checks++; if (chn_o !== 3'd7) $display("FAIL ch7_chn: got %0d want 7", chn_o); else n_pass++;
            n_checks++; if (single_o !== 1'b0) $display("FAIL ch7_single: got %b want 0", single_o); else n_pass++;
            convert(vals[it]);
            if (it == 2) run_i = 1'b0;
            n_checks++; if (scan_done_o !== 1'b1) $display("FAIL ch7_done: got %b want 1", scan_done_o); else n_pass++;
            exp_d = exp_data_q.pop_front();
            n_checks++; if (rd_data_o !== exp_d) $display("FAIL ch7_store: got %h want %h", rd_data_o, exp_d); else n_pass++;
        end
        tick();
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        logic [9:0] exp_d;
        ch_mask_i = 8'h12;
        run_i     = 1'b1;
        wait_start(ok);
        n_checks++; if (!ok) $display("FAIL tmo_start_timeout: got no start want start"); else n_pass++;
        n_checks++; if (chn_o !== 3'd1) $display("FAIL tmo_chn: got %0d want 1", chn_o); else n_pass++;
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (!start_o) begin
                cnt = k;
                break;
            end
        end
        n_checks++; if (cnt != 16) $display("FAIL tmo_len: got %0d want 16", cnt); else n_pass++;
        n_checks++; if (err_o !== 1'b1) $display("FAIL tmo_err: got %b want 1", err_o); else n_pass++;
        wait_start(ok);
        n_checks++; if (!ok) $display("FAIL tmo_retry_timeout: got no start want start"); else n_pass++;
        n_checks++; if (chn_o !== 3'd4) $display("FAIL tmo_next_chn: got %0d want 4", chn_o); else n_pass++;
        n_checks++; if (valid_o !== 8'h85) $display("FAIL tmo_valid: got %h want 85", valid_o); else n_pass++;
        rd_chn_i = 3'd4;
        convert(10'h2C4);
        run_i = 1'b0;
        exp_d = exp_data_q.pop_front();
        n_checks++; if (rd_data_o !== exp_d) $display("FAIL tmo_store4: got %h want %h", rd_data_o, exp_d); else n_pass++;
        n_checks++; if (valid_o !== 8'h95) $display("FAIL tmo_valid4: got %h want 95", valid_o); else n_pass++;
        n_checks++; if (err_o !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", err_o); else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_run_drop();
        bit ok, seen;
        logic [9:0] exp_d;
        ch_mask_i = 8'h08;
        run_i     = 1'b1;
        wait_start(ok);
        n_checks++; if (!ok) $display("FAIL drop_start_timeout: got no start want start"); else n_pass++;
        n_checks++; if (chn_o !== 3'd3) $display("FAIL drop_chn: got %0d want 3", chn_o); else n_pass++;
        rd_chn_i = 3'd3;
        busy_i   = 1'b1;
        tick();
        run_i = 1'b0;
        tick();
        eoc_i  = 1'b1;
        data_i = 10'h1C3;
        exp_data_q.push_back(10'h1C3);
        tick();
        eoc_i  = 1'b0;
        busy_i = 1'b0;
        exp_d  = exp_data_q.pop_front();
        n_checks++; if (rd_data_o !== exp_d) $display("FAIL drop_store: got %h want %h", rd_data_o, exp_d); else n_pass++;
        n_checks++; if (valid_o !== 8'h9D) $display("FAIL drop_valid: got %h want 9d", valid_o); else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (start_o) seen = 1'b1;
        end
        n_checks++; if (seen) $display("FAIL drop_no_restart: got start want none"); else n_pass++;
        ch_mask_i = 8'h00;
        run_i     = 1'b1;
        seen      = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (start_o) seen = 1'b1;
        end
        n_checks++; if (seen) $display("FAIL mask0_idle: got start want none"); else n_pass++;
        run_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok, bad;
        ch_mask_i = 8'h01;
        run_i     = 1'b1;
        wait_start(ok);
        n_checks++; if (!ok) $display("FAIL rmid_start_timeout: got no start want start"); else n_pass++;
        busy_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b1;
        run_i = 1'b0;
        tick();
        rst_i  = 1'b0;
        eoc_i  = 1'b1;
        data_i = 10'h3FF;
        tick();
        eoc_i  = 1'b0;
        busy_i = 1'b0;
        data_i = 10'd0;
        tick();
        n_checks++; if (valid_o !== 8'h00) $display("FAIL rmid_valid: got %h want 00", valid_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL rmid_err: got %b want 0", err_o); else n_pass++;
        n_checks++; if (start_o !== 1'b0) $display("FAIL rmid_start: got %b want 0", start_o); else n_pass++;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            rd_chn_i = 3'(c);
            #1;
            if (rd_data_o !== 10'd0) bad = 1'b1;
        end
        n_checks++; if (bad) $display("FAIL rmid_regs: got nonzero want all 0"); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_divider();
        test_scan_two_channels();
        test_single_channel_diff();
        test_timeout();
        test_run_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
